// File: rtl/spw_tc_pkg.sv
// spw_tc_pkg: shared FSM state, register map and CTRL bit indices for the time-code monitor
package spw_tc_pkg;
  typedef enum logic [1:0] {UNLOCKED = 2'd0, LOCKING = 2'd1, LOCKED = 2'd2} tc_state_e;
  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_TICKS  = 2'd1;
  localparam logic [1:0] ADDR_ERRORS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;
  localparam int CTRL_IRQ_EN       = 0;
  localparam int CTRL_CLR_CNT      = 1;
  localparam int CTRL_CLR_ERR      = 2;
  localparam int CTRL_FORCE_UNLOCK = 3;
endpackage

// File: rtl/spw_sat_counter.sv
// spw_sat_counter: W-bit up counter that sticks at all-ones; synchronous clear beats increment
module spw_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= '0;
    else if (clr) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/spw_timecode_monitor.sv
// spw_timecode_monitor: latches SpaceWire time-codes, tracks +1 mod 64 sequence lock,
// counts ticks/errors and exposes status through a small Avalon-MM slave.
module spw_timecode_monitor
  import spw_tc_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int LOCK_COUNT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick_in,
  input  logic [7:0]  time_in,
  output logic [7:0]  time_o,
  output logic        locked,
  output logic        irq,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata
);
  tc_state_e        state_q;
  logic [3:0]       run_q;
  logic [7:0]       time_q;
  logic [5:0]       exp_q;
  logic             err_sticky_q, irq_en_q;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] tick_cnt, err_cnt;
  logic             ctrl_wr, clr_cnt, clr_err, force_unlock, in_seq, seq_err;
  logic             unused_wd;
  assign ctrl_wr      = write && address == ADDR_CTRL;
  assign clr_cnt      = ctrl_wr && writedata[CTRL_CLR_CNT];
  assign clr_err      = ctrl_wr && writedata[CTRL_CLR_ERR];
  assign force_unlock = ctrl_wr && writedata[CTRL_FORCE_UNLOCK];
  assign in_seq       = time_in[5:0] == exp_q;
  assign seq_err      = tick_in && state_q == LOCKED && !in_seq && !force_unlock;
  assign unused_wd    = ^writedata[31:4];
  // Lock tracking; run_q counts consecutive in-sequence ticks while LOCKING.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= UNLOCKED;
      run_q   <= '0;
    end else if (force_unlock) begin
      state_q <= UNLOCKED;
      run_q   <= '0;
    end else if (tick_in) begin
      case (state_q)
        UNLOCKED: begin
          run_q   <= 4'd1;
          state_q <= LOCK_COUNT <= 1 ? LOCKED : LOCKING;
        end
        LOCKING: begin
          run_q <= in_seq ? run_q + 4'd1 : 4'd1;
          if (in_seq && int'(run_q) + 1 >= LOCK_COUNT) state_q <= LOCKED;
        end
        LOCKED: if (!in_seq) begin
          state_q <= LOCKING;
          run_q   <= 4'd1;
        end
        default: state_q <= UNLOCKED;
      endcase
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      time_q       <= '0;
      exp_q        <= '0;
      err_sticky_q <= 1'b0;
      irq_en_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      if (tick_in) begin
        time_q <= time_in;
        exp_q  <= time_in[5:0] + 6'd1;
      end
      err_sticky_q <= seq_err || (err_sticky_q && !clr_err);
      if (ctrl_wr) irq_en_q <= writedata[CTRL_IRQ_EN];
      if (read) rdata_q <= rdata_d;
    end
  always_comb
    rdata_d = address == ADDR_STATUS ? {20'd0, state_q, err_sticky_q, locked, time_q} :
              address == ADDR_TICKS  ? 32'(tick_cnt) :
              address == ADDR_ERRORS ? 32'(err_cnt) :
                                       {18'd0, exp_q, 7'd0, irq_en_q};
  spw_sat_counter #(.W(CNT_W)) u_tick_cnt (
    .clk(clk), .reset_n(reset_n), .clr(clr_cnt), .inc(tick_in), .q(tick_cnt)
  );
  spw_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .reset_n(reset_n), .clr(clr_cnt), .inc(seq_err), .q(err_cnt)
  );
  assign time_o   = time_q;
  assign locked   = state_q == LOCKED;
  assign irq      = err_sticky_q && irq_en_q;
  assign readdata = rdata_q;
endmodule

// File: tb/tb_spw_timecode_monitor.sv
// tb_spw_timecode_monitor: directed and randomized checks of the time-code monitor against
// a streak-based reference model.
module tb_spw_timecode_monitor;
  localparam int LC = 2;
  logic        clk = 0, reset_n = 0, tick_in = 0, read = 0, write = 0;
  logic [7:0]  time_in = 0;
  logic [1:0]  address = 0;
  logic [31:0] writedata = 0;
  logic [7:0]  time_o, s_time_o;
  logic        locked, irq, s_locked, s_irq;
  logic [31:0] readdata, s_readdata;
  int checks = 0, errors = 0;
  // Model: a lock is a streak of consecutive in-sequence ticks at least LC long.
  bit         m_have, m_sticky, m_irq_en;
  int         m_streak, m_ticks, m_errs;
  logic [7:0] m_time;
  logic [5:0] m_exp;

  spw_timecode_monitor #(.CNT_W(16), .LOCK_COUNT(LC)) dut (
    .clk(clk), .reset_n(reset_n), .tick_in(tick_in), .time_in(time_in), .time_o(time_o),
    .locked(locked), .irq(irq), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata)
  );
  spw_timecode_monitor #(.CNT_W(4), .LOCK_COUNT(LC)) dut_small (
    .clk(clk), .reset_n(reset_n), .tick_in(tick_in), .time_in(time_in), .time_o(s_time_o),
    .locked(s_locked), .irq(s_irq), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(s_readdata)
  );

  always #5 clk = ~clk;

  function automatic int m_state();
    return !m_have ? 0 : (m_streak >= LC ? 2 : 1);
  endfunction

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    logic [1:0] st;
    st = 2'(m_state());
    case (a)
      2'd0: return {20'd0, st, m_sticky, st == 2'd2, m_time};
      2'd1: return 32'(m_ticks);
      2'd2: return 32'(m_errs);
      default: return {18'd0, m_exp, 7'd0, m_irq_en};
    endcase
  endfunction

  task automatic model_reset();
    m_have = 0; m_sticky = 0; m_irq_en = 0; m_streak = 0;
    m_ticks = 0; m_errs = 0; m_time = 0; m_exp = 0;
  endtask

  task automatic cycle(input bit tk, input logic [7:0] t, input bit wr,
                       input logic [1:0] a, input logic [31:0] wd);
    bit force_u, err, was_locked;
    @(negedge clk);
    tick_in = tk; time_in = t; write = wr; address = a; writedata = wd;
    @(negedge clk);
    tick_in = 0; write = 0;
    force_u = wr && a == 2'd3 && wd[3];
    err = 0;
    if (tk) begin
      was_locked = m_state() == 2;
      if (force_u) begin m_have = 0; m_streak = 0; end
      else if (!m_have) begin m_have = 1; m_streak = 1; end
      else if (t[5:0] == m_exp) m_streak = m_streak < 100 ? m_streak + 1 : m_streak;
      else begin err = was_locked; m_streak = 1; end
      m_time = t;
      m_exp = 6'((int'(t[5:0]) + 1) % 64);
      if (m_ticks < 65535) m_ticks++;
    end else if (force_u) begin
      m_have = 0; m_streak = 0;
    end
    if (err && m_errs < 65535) m_errs++;
    if (wr && a == 2'd3) begin
      m_irq_en = wd[0];
      if (wd[1]) begin m_ticks = 0; m_errs = 0; end
      if (wd[2]) m_sticky = 0;
    end
    if (err) m_sticky = 1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read = 1;
    @(negedge clk);
    read = 0;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    model_reset();
    checks++; if ({time_o, locked, irq} !== 10'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", {time_o, locked, irq}); end
    checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata: got %h expected 0", readdata); end
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), d);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_reg%0d: got %h expected 0", i, d); end
    end
  endtask

  task automatic test_lock();
    logic [31:0] d;
    cycle(1, 8'h00, 0, 0, 0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_after1: got %b expected 0", locked); end
    cycle(1, 8'h01, 0, 0, 0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_after2: got %b expected 1", locked); end
    cycle(1, 8'h02, 0, 0, 0);
    checks++; if (time_o !== 8'h02) begin errors++; $display("FAIL lock_time: got %h expected 02", time_o); end
    rd(2'd1, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL lock_ticks: got %h expected 3", d); end
    rd(2'd2, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL lock_errors: got %h expected 0", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    cycle(0, 0, 1, 2'd3, 32'h0A);
    cycle(1, 8'h3C, 0, 0, 0);
    cycle(1, 8'h3D, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 8'((8'h3E + i) & 8'h3F), 0, 0, 0);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL wrap_locked%0d: got %b expected 1", i, locked); end
    end
    rd(2'd3, d);
    checks++; if (d !== 32'h0000_0100) begin errors++; $display("FAIL wrap_ctrl: got %h expected 00000100", d); end
    rd(2'd2, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL wrap_errors: got %h expected 0", d); end
  endtask

  task automatic test_seq_error();
    logic [31:0] d;
    cycle(0, 0, 1, 2'd3, 32'h1);
    cycle(1, 8'h01, 0, 0, 0);
    cycle(1, 8'h02, 0, 0, 0);
    cycle(1, 8'h05, 0, 0, 0);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL seqerr_irq: got %b expected 1", irq); end
    rd(2'd2, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL seqerr_errors: got %h expected 1", d); end
    rd(2'd0, d);
    checks++; if (d !== 32'h0000_0605) begin errors++; $display("FAIL seqerr_status: got %h expected 00000605", d); end
    cycle(0, 0, 1, 2'd3, 32'h5);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL seqerr_irq_clr: got %b expected 0", irq); end
    rd(2'd0, d);
    checks++; if (d !== 32'h0000_0405) begin errors++; $display("FAIL seqerr_status_clr: got %h expected 00000405", d); end
  endtask

  task automatic test_flags();
    logic [31:0] d;
    cycle(0, 0, 1, 2'd3, 32'h8);
    cycle(1, 8'h01, 0, 0, 0);
    cycle(1, 8'h02, 0, 0, 0);
    cycle(1, 8'hC3, 0, 0, 0);
    checks++; if ({time_o, locked} !== {8'hC3, 1'b1}) begin errors++; $display("FAIL flags_out: got %h/%b expected c3/1", time_o, locked); end
    rd(2'd0, d);
    checks++; if (d !== 32'h0000_09C3) begin errors++; $display("FAIL flags_status: got %h expected 000009c3", d); end
    rd(2'd2, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL flags_errors: got %h expected 1", d); end
  endtask

  task automatic test_clear_tick();
    logic [31:0] d;
    cycle(1, 8'h04, 1, 2'd3, 32'h2);
    checks++; if ({time_o, locked} !== {8'h04, 1'b1}) begin errors++; $display("FAIL clrtick_out: got %h/%b expected 04/1", time_o, locked); end
    rd(2'd1, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL clrtick_ticks: got %h expected 0", d); end
    rd(2'd2, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL clrtick_errors: got %h expected 0", d); end
  endtask

  task automatic test_random();
    logic [31:0] d, wd;
    logic [7:0]  t;
    bit          tk, wr;
    logic [1:0]  a;
    for (int i = 0; i < 400; i++) begin
      tk = $urandom_range(0, 3) != 0;
      t  = $urandom_range(0, 4) == 0 ? 8'($urandom) : {2'($urandom), m_exp};
      wr = $urandom_range(0, 9) == 0;
      a  = 2'($urandom);
      wd = {$urandom_range(0, 65535), 12'd0, 4'($urandom)};
      cycle(tk, t, wr, a, wd);
      checks++;
      if ({time_o, locked, irq} !== {m_time, m_state() == 2, m_sticky && m_irq_en}) begin
        errors++;
        $display("FAIL rand_out[%0d]: got %h/%b/%b expected %h/%b/%b", i, time_o, locked, irq,
                 m_time, m_state() == 2, m_sticky && m_irq_en);
      end
      if (i % 16 == 15)
        for (int r = 0; r < 4; r++) begin
          rd(2'(r), d);
          checks++; if (d !== m_reg(2'(r))) begin errors++; $display("FAIL rand_reg%0d[%0d]: got %h expected %h", r, i, d, m_reg(2'(r))); end
        end
    end
  endtask

  task automatic test_saturate_reset();
    logic [31:0] d;
    cycle(0, 0, 1, 2'd3, 32'h2);
    for (int i = 0; i < 20; i++) cycle(1, {2'b00, m_exp}, 0, 0, 0);
    rd(2'd1, d);
    checks++; if (d !== 32'd20) begin errors++; $display("FAIL sat_ticks16: got %h expected 14", d); end
    checks++; if (s_readdata !== 32'h0000_000F) begin errors++; $display("FAIL sat_ticks4: got %h expected 0000000f", s_readdata); end
    checks++; if ({locked, s_locked} !== 2'b11) begin errors++; $display("FAIL sat_locked: got %b expected 11", {locked, s_locked}); end
    @(negedge clk);
    tick_in = 1; time_in = {2'b00, m_exp};
    #2 reset_n = 0;
    #1;
    checks++;
    if ({time_o, locked, irq, readdata, s_time_o, s_locked, s_irq, s_readdata} !== 84'd0) begin
      errors++;
      $display("FAIL async_reset: got %h/%b/%b/%h small %h/%b/%b/%h expected all 0",
               time_o, locked, irq, readdata, s_time_o, s_locked, s_irq, s_readdata);
    end
    tick_in = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    model_reset();
    rd(2'd1, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL post_reset_ticks: got %h expected 0", d); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_wrap();
    test_seq_error();
    test_flags();
    test_clear_tick();
    test_random();
    test_saturate_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
